// File: rtl/spi_rx_ctrl.sv
// spi_rx_ctrl: SPI master receive controller with an integrated receive FIFO.
// On a start request it drops chip-select, generates SCLK in the latched
// CPOL/CPHA mode, shifts receive_len_i words in MSB-first from sdi_i, pushes
// each word into the FIFO and pulses rx_ctrl_eot_o when the transfer is done.
//
// Ports:
//   clk_i, rstn_i    clock, asynchronous active-low reset
//   rdata_o          FIFO read data, valid the cycle after rd_en_i
//   rd_en_i          FIFO read strobe (ignored while empty)
//   empty_o, full_o  FIFO flags
//   elements_o       FIFO occupancy
//   cpol_i, cpoa_i   SPI clock polarity / phase, latched while idle
//   sdi_i            serial data in, synchronous to clk_i
//   spi_bus_clk_o    SCLK
//   cs_n_o           chip-select, active-low
//   receive_len_i    words per transfer, latched while idle
//   rx_ctrl_st_i     start request, acted on while idle
//   rx_ctrl_eot_o    one-cycle end-of-transfer pulse
//   rx_busy_o        high whenever the controller is not idle
module spi_rx_ctrl #(
    parameter int          DLY          = 1,
    parameter int unsigned SPI_RX_DWIDE = 32,
    parameter int unsigned FIFO_DEPTH   = 32,
    parameter int unsigned CLK_DIV      = 4
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    output logic [SPI_RX_DWIDE-1:0]     rdata_o,
    input  logic                        rd_en_i,
    output logic                        empty_o,
    output logic                        full_o,
    output logic [$clog2(FIFO_DEPTH):0] elements_o,
    input  logic                        cpol_i,
    input  logic                        cpoa_i,
    input  logic                        sdi_i,
    output logic                        spi_bus_clk_o,
    output logic                        cs_n_o,
    input  logic [31:0]                 receive_len_i,
    input  logic                        rx_ctrl_st_i,
    output logic                        rx_ctrl_eot_o,
    output logic                        rx_busy_o
);

    localparam int unsigned W    = SPI_RX_DWIDE;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BITW = $clog2(SPI_RX_DWIDE + 1);
    localparam int unsigned LENW = 32;

    // Reject illegal parameterisations at elaboration. DLY is accepted for
    // interface compatibility only; the RTL itself carries no delays.
    if (DLY < 0 || SPI_RX_DWIDE < 2 || FIFO_DEPTH < 2 || CLK_DIV < 1 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("spi_rx_ctrl: illegal parameter value");
    end

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_WAIT,
        RX_SHIFT,
        RX_PUSH,
        RX_EOT
    } state_e;

    // Control path state
    state_e            state_q, state_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [LENW-1:0]   len_q, len_d;
    logic [LENW-1:0]   cnt_q, cnt_d;
    logic [DIVW-1:0]   div_q, div_d;
    logic              phase_q, phase_d;
    logic [BITW-1:0]   bit_q, bit_d;
    logic [W-1:0]      shift_q, shift_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic              eot_q, eot_d;
    logic              busy_q, busy_d;
    logic              push_c;

    // FIFO state
    logic [W-1:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic [W-1:0]      rdata_q, rdata_d;
    logic              pop_c;

    // Control state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= RX_IDLE;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            eot_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            eot_q   <= eot_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, SCLK generation, sampling and registered-output decode
    always_comb begin
        state_d = state_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push_c  = 1'b0;

        case (state_q)
            RX_IDLE: begin
                cpol_d  = cpol_i;
                cpha_d  = cpoa_i;
                len_d   = receive_len_i;
                div_d   = '0;
                phase_d = 1'b0;
                bit_d   = '0;
                if (rx_ctrl_st_i) begin
                    cnt_d = '0;
                    // Decide on the length value being latched at this edge.
                    state_d = (receive_len_i == '0) ? RX_EOT : RX_WAIT;
                end
            end

            RX_WAIT: begin
                div_d   = '0;
                phase_d = 1'b0;
                bit_d   = '0;
                if (!full_q) begin
                    state_d = RX_SHIFT;
                end
            end

            RX_SHIFT: begin
                if (div_q == DIVW'(CLK_DIV - 1)) begin
                    div_d   = '0;
                    phase_d = ~phase_q;
                    // phase 0 -> leading edge (CPHA=0), phase 1 -> trailing (CPHA=1)
                    if (phase_q == cpha_q) begin
                        shift_d = {shift_q[W-2:0], sdi_i};
                    end
                    if (phase_q) begin
                        bit_d = bit_q + BITW'(1);
                        if (bit_q == BITW'(SPI_RX_DWIDE - 1)) begin
                            state_d = RX_PUSH;
                        end
                    end
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end

            RX_PUSH: begin
                push_c  = 1'b1;
                cnt_d   = cnt_q + LENW'(1);
                state_d = (cnt_d == len_q) ? RX_EOT : RX_WAIT;
            end

            RX_EOT: begin
                state_d = RX_IDLE;
            end

            default: begin
                state_d = RX_IDLE;
            end
        endcase

        // Outputs are registered from next-state values so they line up with the state.
        sclk_d = phase_d ^ cpol_d;
        cs_n_d = !((state_d == RX_WAIT) || (state_d == RX_SHIFT) || (state_d == RX_PUSH));
        eot_d  = (state_d == RX_EOT);
        busy_d = (state_d != RX_IDLE);
    end

    // FIFO pointer/occupancy next-state
    always_comb begin
        pop_c    = rd_en_i && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            rdata_d  = mem_q[rd_ptr_q];
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(FIFO_DEPTH));
    end

    // FIFO control registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            rdata_q  <= rdata_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rdata_o       = rdata_q;
    assign empty_o       = empty_q;
    assign full_o        = full_q;
    assign elements_o    = count_q;
    assign spi_bus_clk_o = sclk_q;
    assign cs_n_o        = cs_n_q;
    assign rx_ctrl_eot_o = eot_q;
    assign rx_busy_o     = busy_q;

endmodule

// File: tb/tb_spi_rx_ctrl.sv
// tb_spi_rx_ctrl: directed bench for spi_rx_ctrl with a behavioural SPI slave.
module tb_spi_rx_ctrl;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned DIV   = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] rdata;
    logic        rd_en = 1'b0;
    logic        empty;
    logic        full;
    logic [5:0]  elements;
    logic        cpol = 1'b0;
    logic        cpoa = 1'b0;
    logic        sdi = 1'b0;
    logic        sclk;
    logic        cs_n;
    logic [31:0] rlen = '0;
    logic        st = 1'b0;
    logic        eot;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    spi_rx_ctrl #(
        .DLY          (1),
        .SPI_RX_DWIDE (DW),
        .FIFO_DEPTH   (DEPTH),
        .CLK_DIV      (DIV)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .rdata_o       (rdata),
        .rd_en_i       (rd_en),
        .empty_o       (empty),
        .full_o        (full),
        .elements_o    (elements),
        .cpol_i        (cpol),
        .cpoa_i        (cpoa),
        .sdi_i         (sdi),
        .spi_bus_clk_o (sclk),
        .cs_n_o        (cs_n),
        .receive_len_i (rlen),
        .rx_ctrl_st_i  (st),
        .rx_ctrl_eot_o (eot),
        .rx_busy_o     (busy)
    );

    always #5 clk = ~clk;

    // Slave model: words sw[] are streamed MSB-first as one continuous bit stream
    // per chip-select assertion. On the sample edge the line is inverted, so a
    // master sampling on the wrong edge reads corrupted data.
    logic [31:0] sw [0:63];
    int          sbit      = 0;
    int          tog_cs    = 0;
    int          tog_all   = 0;
    logic        sclk_prev = 1'b0;
    logic        lead;

    function automatic logic bitval(input int i);
        if (i < 64 * 32) return sw[i / 32][31 - (i % 32)];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (sclk !== sclk_prev) tog_all++;
        if (cs_n !== 1'b0) begin
            sbit = 0;
            sdi  = cpoa ? 1'b0 : bitval(0);
        end else if (sclk !== sclk_prev) begin
            tog_cs++;
            lead = (sclk != cpol);
            if (lead == !cpoa) begin
                sdi = ~sdi;
            end else if (cpoa) begin
                sdi = bitval(sbit);
                sbit++;
            end else begin
                sbit++;
                sdi = bitval(sbit);
            end
        end
        sclk_prev = sclk;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulses start for one cycle; returns #1 after the edge that sampled it.
    task automatic start_xfer(input logic [31:0] len);
        rlen = len;
        @(posedge clk); #1;
        st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
    endtask

    // n counts the current cycle as 1; n reaching max means timeout.
    task automatic wait_eot(input int max, output int n);
        n = 1;
        while (eot !== 1'b1 && n < max) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_full(input int max, output int n);
        n = 1;
        while (full !== 1'b1 && n < max) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic read_word(output logic [31:0] d);
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        d = rdata;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
        checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
        checks++; if (eot !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_eot_busy got=%b/%b exp=0/0", eot, busy); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags empty/full got=%b/%b exp=1/0", empty, full); end
        checks++; if (elements !== 6'd0 || rdata !== 32'd0) begin failures++; $display("FAIL reset_fifo elements=%0d rdata=%h exp 0/0", elements, rdata); end
        @(negedge clk);
        rstn = 1'b1;
        idle(2);
        checks++; if (cs_n !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle cs_n/busy got=%b/%b exp=1/0", cs_n, busy); end
    endtask

    task automatic test_mode0();
        int n;
        int t0;
        logic [31:0] d;
        cpol = 1'b0; cpoa = 1'b0;
        sw[0] = 32'hA5A5_5A5A;
        idle(3);
        t0 = tog_cs;
        start_xfer(32'd1);
        checks++; if (cs_n !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL mode0_wait cs_n/busy got=%b/%b exp=0/1", cs_n, busy); end
        wait_eot(400, n);
        checks++; if (n !== 131) begin failures++; $display("FAIL mode0_eot_cycle got=%0d exp=131", n); end
        checks++; if (tog_cs - t0 !== 64) begin failures++; $display("FAIL mode0_sclk_edges got=%0d exp=64", tog_cs - t0); end
        @(posedge clk); #1;
        checks++; if (eot !== 1'b0 || cs_n !== 1'b1) begin failures++; $display("FAIL mode0_after_eot eot/cs_n got=%b/%b exp=0/1", eot, cs_n); end
        checks++; if (elements !== 6'd1) begin failures++; $display("FAIL mode0_elements got=%0d exp=1", elements); end
        read_word(d);
        checks++; if (d !== 32'hA5A5_5A5A) begin failures++; $display("FAIL mode0_data got=%h exp=a5a55a5a", d); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL mode0_empty got=%b exp=1", empty); end
    endtask

    task automatic test_modes();
        int n;
        int t0;
        logic [31:0] d;
        logic [31:0] exp_w [0:2];
        exp_w[0] = 32'h0000_0001;
        exp_w[1] = 32'h8000_0000;
        exp_w[2] = 32'hFFFF_FFFE;
        for (int m = 0; m < 4; m++) begin
            cpol = (m >= 2);
            cpoa = (m % 2 == 1);
            for (int k = 0; k < 3; k++) sw[k] = exp_w[k];
            idle(3);
            checks++; if (sclk !== cpol) begin failures++; $display("FAIL mode%0d_idle_level got=%b exp=%b", m, sclk, cpol); end
            t0 = tog_cs;
            start_xfer(32'd3);
            wait_eot(800, n);
            checks++; if (n !== 391) begin failures++; $display("FAIL mode%0d_eot_cycle got=%0d exp=391", m, n); end
            checks++; if (tog_cs - t0 !== 192) begin failures++; $display("FAIL mode%0d_sclk_edges got=%0d exp=192", m, tog_cs - t0); end
            checks++; if (sclk !== cpol) begin failures++; $display("FAIL mode%0d_end_level got=%b exp=%b", m, sclk, cpol); end
            @(posedge clk); #1;
            checks++; if (elements !== 6'd3) begin failures++; $display("FAIL mode%0d_elements got=%0d exp=3", m, elements); end
            for (int k = 0; k < 3; k++) begin
                read_word(d);
                checks++; if (d !== exp_w[k]) begin failures++; $display("FAIL mode%0d_word%0d got=%h exp=%h", m, k, d, exp_w[k]); end
            end
        end
    endtask

    task automatic test_len0();
        int a;
        bit cs_seen;
        cpol = 1'b0; cpoa = 1'b0;
        idle(3);
        a = tog_all;
        start_xfer(32'd0);
        checks++; if (eot !== 1'b1 || cs_n !== 1'b1) begin failures++; $display("FAIL len0_eot eot/cs_n got=%b/%b exp=1/1", eot, cs_n); end
        cs_seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (cs_n !== 1'b1) cs_seen = 1'b1;
        end
        checks++; if (cs_seen) begin failures++; $display("FAIL len0_cs_n got=asserted exp=never"); end
        checks++; if (eot !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL len0_idle eot/busy got=%b/%b exp=0/0", eot, busy); end
        checks++; if (tog_all !== a) begin failures++; $display("FAIL len0_sclk toggles got=%0d exp=0", tog_all - a); end
        checks++; if (elements !== 6'd0) begin failures++; $display("FAIL len0_elements got=%0d exp=0", elements); end
    endtask

    task automatic test_full();
        int n;
        int t0;
        logic [31:0] d;
        cpol = 1'b0; cpoa = 1'b0;
        for (int i = 0; i < 34; i++) sw[i] = 32'hC300_0000 + 32'(i);
        idle(3);
        t0 = tog_cs;
        start_xfer(32'd34);
        wait_full(5000, n);
        checks++; if (n !== 4161) begin failures++; $display("FAIL full_cycle got=%0d exp=4161", n); end
        idle(20);
        checks++; if (sclk !== 1'b0 || cs_n !== 1'b0) begin failures++; $display("FAIL full_stall sclk/cs_n got=%b/%b exp=0/0", sclk, cs_n); end
        checks++; if (elements !== 6'd32 || busy !== 1'b1 || eot !== 1'b0) begin failures++; $display("FAIL full_stall elements=%0d busy=%b eot=%b exp 32/1/0", elements, busy, eot); end
        read_word(d);
        checks++; if (d !== 32'hC300_0000) begin failures++; $display("FAIL full_read0 got=%h exp=c3000000", d); end
        wait_full(400, n);
        checks++; if (n !== 131) begin failures++; $display("FAIL full_word33 cycle got=%0d exp=131", n); end
        read_word(d);
        checks++; if (d !== 32'hC300_0001) begin failures++; $display("FAIL full_read1 got=%h exp=c3000001", d); end
        wait_eot(400, n);
        checks++; if (n !== 131) begin failures++; $display("FAIL full_eot cycle got=%0d exp=131", n); end
        checks++; if (tog_cs - t0 !== 2176) begin failures++; $display("FAIL full_sclk_edges got=%0d exp=2176", tog_cs - t0); end
        @(posedge clk); #1;
        checks++; if (elements !== 6'd32) begin failures++; $display("FAIL full_end_elements got=%0d exp=32", elements); end
        for (int i = 2; i < 34; i++) begin
            read_word(d);
            checks++; if (d !== sw[i]) begin failures++; $display("FAIL full_drain%0d got=%h exp=%h", i, d, sw[i]); end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [31:0] d;
        cpol = 1'b1; cpoa = 1'b0;
        sw[0] = 32'h1111_2222;
        sw[1] = 32'h3333_4444;
        idle(3);
        start_xfer(32'd2);
        idle(180);
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (sclk !== 1'b0 || cs_n !== 1'b1) begin failures++; $display("FAIL rstmid_pins sclk/cs_n got=%b/%b exp=0/1", sclk, cs_n); end
        checks++; if (busy !== 1'b0 || eot !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl busy/eot got=%b/%b exp=0/0", busy, eot); end
        checks++; if (elements !== 6'd0 || empty !== 1'b1 || full !== 1'b0 || rdata !== 32'd0) begin
            failures++; $display("FAIL rstmid_fifo elements=%0d empty=%b full=%b rdata=%h exp 0/1/0/0", elements, empty, full, rdata);
        end
        @(negedge clk);
        rstn = 1'b1;
        sw[0] = 32'hDEAD_BEEF;
        idle(3);
        checks++; if (sclk !== 1'b1) begin failures++; $display("FAIL rstmid_idle_level got=%b exp=1", sclk); end
        start_xfer(32'd1);
        wait_eot(400, n);
        checks++; if (n !== 131) begin failures++; $display("FAIL rstmid_eot_cycle got=%0d exp=131", n); end
        @(posedge clk); #1;
        checks++; if (elements !== 6'd1) begin failures++; $display("FAIL rstmid_elements got=%0d exp=1", elements); end
        read_word(d);
        checks++; if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rstmid_data got=%h exp=deadbeef", d); end
    endtask

    task automatic test_hold_start();
        int n;
        logic [31:0] d;
        logic [31:0] exp_w [0:2];
        cpol = 1'b0; cpoa = 1'b1;
        sw[0] = 32'h1234_5678;
        sw[1] = 32'h9ABC_DEF0;
        exp_w[0] = 32'h1234_5678;
        exp_w[1] = 32'h9ABC_DEF0;
        exp_w[2] = 32'h1234_5678;
        rlen = 32'd2;
        idle(3);
        st = 1'b1;
        @(posedge clk); #1;
        rlen = 32'd1;
        wait_eot(600, n);
        checks++; if (n !== 261) begin failures++; $display("FAIL hold_eot_cycle got=%0d exp=261", n); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || cs_n !== 1'b1) begin failures++; $display("FAIL hold_idle busy/cs_n got=%b/%b exp=0/1", busy, cs_n); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1 || cs_n !== 1'b0) begin failures++; $display("FAIL hold_restart busy/cs_n got=%b/%b exp=1/0", busy, cs_n); end
        st = 1'b0;
        wait_eot(400, n);
        checks++; if (n !== 131) begin failures++; $display("FAIL hold_second_eot got=%0d exp=131", n); end
        @(posedge clk); #1;
        checks++; if (elements !== 6'd3) begin failures++; $display("FAIL hold_elements got=%0d exp=3", elements); end
        for (int k = 0; k < 3; k++) begin
            read_word(d);
            checks++; if (d !== exp_w[k]) begin failures++; $display("FAIL hold_word%0d got=%h exp=%h", k, d, exp_w[k]); end
        end
        read_word(d);
        checks++; if (d !== 32'h1234_5678 || elements !== 6'd0 || empty !== 1'b1) begin
            failures++; $display("FAIL empty_read rdata=%h elements=%0d empty=%b exp 12345678/0/1", d, elements, empty);
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_len0();
        test_full();
        test_reset_mid();
        test_hold_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
